// File: rtl/sort_host.sv
// sort_host: loads N bytes into the byte sorter, starts it, and streams the sorted result back out.
// Define SORT_HOST_DESC_EN to read the sorter back in descending order.
module sort_host #(
  parameter int N      = 8,
  parameter int AW     = 3,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          s_start,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_datain,
  input  logic [DW-1:0] s_dataout,
  input  logic          s_ready
);
  localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] LAST = AW'(N-1);
  typedef enum logic [2:0] {LOAD, FLUSH, START, WAIT_BUSY, WAIT_DONE, RD_ADDR, RD_WAIT, EMIT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, s_addr_q, s_addr_d, rd_addr;
  logic [LW-1:0] lat_q, lat_d;
  logic [DW-1:0] s_datain_q, s_datain_d, out_data_q, out_data_d;
  logic s_start_q, s_start_d, s_wr_q, s_wr_d, out_valid_q, out_valid_d;
  logic busy_q, busy_d, done_q, done_d;
  logic last;
`ifdef SORT_HOST_DESC_EN
  assign rd_addr = LAST - idx_q;
`else
  assign rd_addr = idx_q;
`endif
  assign last      = idx_q == LAST;
  assign in_ready  = state_q == LOAD;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign s_start   = s_start_q;
  assign s_wr      = s_wr_q;
  assign s_addr    = s_addr_q;
  assign s_datain  = s_datain_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      lat_q       <= '0;
      s_start_q   <= 1'b0;
      s_wr_q      <= 1'b0;
      s_addr_q    <= '0;
      s_datain_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      s_start_q   <= s_start_d;
      s_wr_q      <= s_wr_d;
      s_addr_q    <= s_addr_d;
      s_datain_q  <= s_datain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    s_start_d   = 1'b0;
    s_wr_d      = 1'b0;
    s_addr_d    = s_addr_q;
    s_datain_d  = s_datain_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      LOAD: if (in_valid) begin
        s_wr_d     = 1'b1;
        s_addr_d   = idx_q;
        s_datain_d = in_data;
        busy_d     = 1'b1;
        idx_d      = last ? '0 : idx_q + 1'b1;
        state_d    = last ? FLUSH : LOAD;
      end
      FLUSH: state_d = START;
      START: begin
        s_start_d = 1'b1;
        state_d   = WAIT_BUSY;
      end
      // ready is stale while start is still on the wire
      WAIT_BUSY: if (!s_start_q && !s_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (s_ready) begin
        idx_d   = '0;
        state_d = RD_ADDR;
      end
      RD_ADDR: begin
        s_addr_d = rd_addr;
        lat_d    = '0;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LW'(RD_LAT-1)) begin
          out_data_d  = s_dataout;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: if (out_ready) begin
        out_valid_d = 1'b0;
        done_d      = last;
        busy_d      = !last;
        idx_d       = last ? '0 : idx_q + 1'b1;
        state_d     = last ? LOAD : RD_ADDR;
      end
      default: state_d = LOAD;
    endcase
  end
endmodule
